// File: rtl/gol_pkg.sv
// Shared types and helpers for the Game-of-Life sweep controller.
// Holds the sweep FSM state encoding and the coordinate width helper.
package gol_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        SWAP,
        DONE
    } sweep_state_t;

    // Address width for a dimension of n cells; never narrower than one bit.
    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sweep_coord_cnt.sv
// Registered raster coordinate counter: x runs fastest, then y, wrapping to (0,0).
// o_last flags the final cell (FIELD_W-1, FIELD_H-1).
module sweep_coord_cnt
    import gol_pkg::*;
#(
    parameter int FIELD_W = 64,
    parameter int FIELD_H = 48
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_adv,
    output logic [coord_w(FIELD_W)-1:0]  o_x,
    output logic [coord_w(FIELD_H)-1:0]  o_y,
    output logic                         o_last
);

    localparam int XW = coord_w(FIELD_W);
    localparam int YW = coord_w(FIELD_H);
    localparam logic [XW-1:0] X_LAST = XW'(FIELD_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FIELD_H - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    // Explicit end-of-row/column compares keep non-power-of-2 fields correct.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (i_adv) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign o_x    = x_q;
    assign o_y    = y_q;
    assign o_last = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/gol_sweep_ctrl.sv
// Sequences one Game-of-Life generation: raster request issue, drain, swap, done.
// Optional generation counter on o_gen_cnt when GOL_GEN_COUNTER_EN is defined.
module gol_sweep_ctrl
    import gol_pkg::*;
#(
    parameter int FIELD_W         = 64,
    parameter int FIELD_H         = 48,
    parameter int MAX_OUTSTANDING = 4
`ifdef GOL_GEN_COUNTER_EN
    ,
    parameter int GEN_CNT_W       = 16
`endif
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic                         i_run,
    output logic                         o_req_valid,
    input  logic                         i_req_ready,
    output logic [coord_w(FIELD_W)-1:0]  o_req_x,
    output logic [coord_w(FIELD_H)-1:0]  o_req_y,
    input  logic                         i_rsp_valid,
    output logic                         o_swap,
    output logic                         o_done,
    output logic                         o_busy
`ifdef GOL_GEN_COUNTER_EN
    ,
    output logic [GEN_CNT_W-1:0]         o_gen_cnt
`endif
);

    localparam int OW = coord_w(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

    sweep_state_t  state_q, state_d;
    logic [OW-1:0] out_q, out_d;
    logic          accept;
    logic          rsp_take;
    logic          coord_last;

    sweep_coord_cnt #(
        .FIELD_W (FIELD_W),
        .FIELD_H (FIELD_H)
    ) u_coord (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_adv  (accept),
        .o_x    (o_req_x),
        .o_y    (o_req_y),
        .o_last (coord_last)
    );

    assign accept   = o_req_valid && i_req_ready;
    assign rsp_take = i_rsp_valid && (out_q != '0);

    always_comb begin
        out_d = out_q;
        if (accept && !rsp_take) begin
            out_d = out_q + OW'(1);
        end else if (!accept && rsp_take) begin
            out_d = out_q - OW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // DRAIN looks at out_d so a response landing this cycle releases it at once.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_start) state_d = ISSUE;
            ISSUE:   if (accept && coord_last) state_d = DRAIN;
            DRAIN:   if (out_d == '0) state_d = SWAP;
            SWAP:    state_d = DONE;
            DONE:    state_d = i_run ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_req_valid = 1'b0;
        o_swap      = 1'b0;
        o_done      = 1'b0;
        o_busy      = (state_q != IDLE);
        unique case (state_q)
            ISSUE:   o_req_valid = (out_q < OUT_MAX);
            SWAP:    o_swap = 1'b1;
            DONE:    o_done = 1'b1;
            default: ;
        endcase
    end

`ifdef GOL_GEN_COUNTER_EN
    logic [GEN_CNT_W-1:0] gen_cnt_q, gen_cnt_d;

    always_comb begin
        gen_cnt_d = gen_cnt_q;
        if (state_q == DONE) begin
            gen_cnt_d = gen_cnt_q + GEN_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gen_cnt_q <= '0;
        end else begin
            gen_cnt_q <= gen_cnt_d;
        end
    end

    assign o_gen_cnt = gen_cnt_q;
`endif

endmodule
